// File: rtl/sample_stream_buffer_if.sv
// Stream bundle between the filter output, the sample buffer and its consumer.
// slave is the buffer side; master is the filter/consumer (testbench) side.
interface sample_stream_buffer_if #(
  parameter int unsigned IN_WIDTH = 12,
  parameter int unsigned DEPTH    = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [IN_WIDTH-1:0] in_data;
  logic                in_strobe;
  logic                in_valid;
  logic [IN_WIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [LW-1:0]       level;
  logic                overflow;
  logic [15:0]         drop_count;
  logic                clear_ovf;

  modport slave (
    input  in_data, in_strobe, in_valid, out_ready, clear_ovf,
    output out_data, out_valid, level, overflow, drop_count
  );

  modport master (
    output in_data, in_strobe, in_valid, out_ready, clear_ovf,
    input  out_data, out_valid, level, overflow, drop_count
  );
endinterface

// File: rtl/sample_stream_buffer.sv
// Captures strobed filter samples (offset-binary -> two's complement), buffers them
// in a FWFT FIFO with registered head, and reports overflow with a sticky flag/counter.
module sample_stream_buffer #(
  parameter int unsigned IN_WIDTH   = 12,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned OFFSET_BIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sample_stream_buffer_if.slave bus
);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned LW       = PW + 1;
  localparam logic        MSB_FLIP = (OFFSET_BIN != 0);

  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]       level, level_nxt;
  logic [IN_WIDTH-1:0] out_data;
  logic                out_valid;
  logic                overflow;
  logic [15:0]         drop_count;

  logic [IN_WIDTH-1:0] stored;
  logic                wr, pop, full, wr_acc, drop;

  always_comb begin
    stored     = {bus.in_data[IN_WIDTH-1] ^ MSB_FLIP, bus.in_data[IN_WIDTH-2:0]};
    wr         = bus.in_strobe & bus.in_valid;
    pop        = out_valid & bus.out_ready;
    full       = (level == LW'(DEPTH));
    wr_acc     = wr & (~full | pop);
    drop       = wr & full & ~pop;
    rd_ptr_nxt = rd_ptr + PW'(1);
    level_nxt  = level;
    case ({wr_acc, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr] <= stored;
  end

  // out_data mirrors mem[rd_ptr]; on a pop from a single-entry FIFO the
  // sample being written this cycle becomes the new head directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (pop) begin
        if (level > LW'(1))
          out_data <= mem[rd_ptr_nxt];
        else if (wr_acc)
          out_data <= stored;
      end else if (wr_acc && level == '0) begin
        out_data <= stored;
      end
    end
  end

  // A drop coinciding with clear_ovf restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (bus.clear_ovf)
        drop_count <= 16'd1;
      else if (drop_count != '1)
        drop_count <= drop_count + 16'd1;
    end else if (bus.clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign bus.out_data   = out_data;
  assign bus.out_valid  = out_valid;
  assign bus.level      = level;
  assign bus.overflow   = overflow;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_sample_stream_buffer.sv
// Directed checks of capture format, FWFT timing, full/overflow handling and reset,
// followed by a randomized backpressure stream against a queue scoreboard.
module tb_sample_stream_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sample_stream_buffer_if #(.IN_WIDTH(12), .DEPTH(16)) bus ();

  sample_stream_buffer #(.IN_WIDTH(12), .DEPTH(16), .OFFSET_BIN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".level"},      32'(bus.level),      32'd0);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, ".out_data"},   32'(bus.out_data),   32'd0);
    chk({tag, ".overflow"},   32'(bus.overflow),   32'd0);
    chk({tag, ".drop_count"}, 32'(bus.drop_count), 32'd0);
  endtask

  logic [11:0] sb_q [$];
  logic [11:0] d;
  logic [11:0] exp_d;

  initial begin
    rst = 1'b1;
    bus.in_data = '0; bus.in_strobe = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b0; bus.clear_ovf = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    // 1: single sample, 0x800 offset-binary is zero
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_strobe = 1'b1; bus.in_data = 12'h800;
    step();
    bus.in_strobe = 1'b0;
    chk("t1.valid", 32'(bus.out_valid), 32'd1);
    chk("t1.data",  32'(bus.out_data),  32'h000);
    chk("t1.level", 32'(bus.level),     32'd1);
    step();
    chk("t1.valid_after", 32'(bus.out_valid), 32'd0);
    chk("t1.level_after", 32'(bus.level),     32'd0);

    // 2: fill to 16 with consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      bus.in_strobe = 1'b1; bus.in_data = 12'(12'h800 + i);
      step();
    end
    bus.in_strobe = 1'b0;
    chk("t2.level",    32'(bus.level),    32'd16);
    chk("t2.overflow", 32'(bus.overflow), 32'd0);
    chk("t2.head",     32'(bus.out_data), 32'h001);

    // 3: three drops while full, then clear_ovf coinciding with a fourth drop
    for (int i = 0; i < 3; i++) begin
      bus.in_strobe = 1'b1; bus.in_data = 12'h8AA;
      step();
    end
    bus.in_strobe = 1'b0;
    chk("t3.drops",    32'(bus.drop_count), 32'd3);
    chk("t3.overflow", 32'(bus.overflow),   32'd1);
    chk("t3.level",    32'(bus.level),      32'd16);
    chk("t3.head",     32'(bus.out_data),   32'h001);
    bus.clear_ovf = 1'b1; bus.in_strobe = 1'b1; bus.in_data = 12'h8BB;
    step();
    bus.clear_ovf = 1'b0; bus.in_strobe = 1'b0;
    chk("t3.clr_ovf",   32'(bus.overflow),   32'd1);
    chk("t3.clr_drops", 32'(bus.drop_count), 32'd1);

    // 4: write concurrent with pop while full; then drain in order
    bus.out_ready = 1'b1; bus.in_strobe = 1'b1; bus.in_data = 12'h8FF;
    step();
    bus.in_strobe = 1'b0;
    chk("t4.level", 32'(bus.level),      32'd16);
    chk("t4.drops", 32'(bus.drop_count), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      chk($sformatf("t4.order%0d", i), 32'(bus.out_data), 32'(i));
      step();
    end
    chk("t4.last_valid", 32'(bus.out_valid), 32'd1);
    chk("t4.last_data",  32'(bus.out_data),  32'h0FF);
    step();
    chk("t4.empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t4.empty_level", 32'(bus.level),     32'd0);
    bus.clear_ovf = 1'b1;
    step();
    bus.clear_ovf = 1'b0;
    chk("t4.cleared_ovf",   32'(bus.overflow),   32'd0);
    chk("t4.cleared_drops", 32'(bus.drop_count), 32'd0);

    // 5: strobes without in_valid are ignored
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_strobe = 1'b1; bus.in_data = 12'h123;
      step();
      bus.in_strobe = 1'b0;
      step();
    end
    chk("t5.level", 32'(bus.level),      32'd0);
    chk("t5.drops", 32'(bus.drop_count), 32'd0);
    chk("t5.valid", 32'(bus.out_valid),  32'd0);

    // 5b: reset mid-stream with a strobe during the reset cycle
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_strobe = 1'b1; bus.in_data = 12'(12'h900 + i);
      step();
    end
    chk("t5.level5", 32'(bus.level), 32'd5);
    rst = 1'b1; bus.out_ready = 1'b1;
    step();
    rst = 1'b0; bus.in_strobe = 1'b0;
    chk_reset_state("t5.rst");

    // 6: random 30% ready against a strobe every 12 cycles
    for (int c = 0; c < 3000 * 12; c++) begin
      bus.out_ready = ($urandom_range(0, 99) < 30);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("t6.spurious", 32'(bus.out_data), 32'hDEAD);
        end else begin
          exp_d = sb_q.pop_front();
          chk("t6.data", 32'(bus.out_data), 32'(exp_d));
        end
      end
      if (c % 12 == 0) begin
        d = 12'($urandom);
        bus.in_strobe = 1'b1; bus.in_data = d;
        sb_q.push_back({~d[11], d[10:0]});
      end else begin
        bus.in_strobe = 1'b0;
      end
      step();
    end
    bus.in_strobe = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && bus.out_valid; c++) begin
      if (sb_q.size() == 0) begin
        chk("t6.drain_spurious", 32'(bus.out_data), 32'hDEAD);
      end else begin
        exp_d = sb_q.pop_front();
        chk("t6.drain_data", 32'(bus.out_data), 32'(exp_d));
      end
      step();
    end
    chk("t6.remaining", 32'(sb_q.size()),   32'd0);
    chk("t6.valid_end", 32'(bus.out_valid), 32'd0);
    chk("t6.level_end", 32'(bus.level),     32'd0);
    chk("t6.overflow",  32'(bus.overflow),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
